// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data-memory responder for the MEM stage: adds wait states, BUSY stall and READY/ERR response.
// Optional build macro DMEM_SIGN_EXTEND_EN sign-extends byte/halfword loads (zero-extended when undefined).
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              READY,
  output logic              ERR,
  output logic              BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       di_q, di_d;
  logic [31:0]       do_q, do_d;
  logic              err_q, err_d;

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              misalign;
  logic [31:0]       rd_data;
  logic [31:0]       resp_data;
  logic              mem_we;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      di_q    <= '0;
      do_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    di_d    = di_q;
    do_d    = do_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          rw_d   = RW;
          size_d = SIZE;
          addr_d = ADDR;
          di_d   = DI;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        do_d    = resp_data;
        err_d   = misalign;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Aligned accesses never cross the end of the array, so the +1..+3 byte addresses never wrap.
  always_comb begin
    a1 = addr_q + ADDR_W'(1);
    a2 = addr_q + ADDR_W'(2);
    a3 = addr_q + ADDR_W'(3);
    b0 = mem[addr_q];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    misalign = (size_q == 2'b11) ||
               ((size_q == 2'b01) && addr_q[0]) ||
               ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    case (size_q)
`ifdef DMEM_SIGN_EXTEND_EN
      2'b00:   rd_data = {{24{b0[7]}}, b0};
      2'b01:   rd_data = {{16{b0[7]}}, b0, b1};
`else
      2'b00:   rd_data = {24'b0, b0};
      2'b01:   rd_data = {16'b0, b0, b1};
`endif
      default: rd_data = {b0, b1, b2, b3};
    endcase
    resp_data = (misalign || rw_q) ? 32'b0 : rd_data;
    mem_we    = (state_q == S_RESP) && rw_q && !misalign;
  end

  always_comb begin
    READY = (state_q == S_RESP);
    ERR   = (state_q == S_RESP) ? misalign : err_q;
    DO    = (state_q == S_RESP) ? resp_data : do_q;
    BUSY  = (state_q == S_WAIT) || ((state_q == S_IDLE) && REQ);
  end

  // Storage has no reset; the write lands on the edge that leaves RESP.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      case (size_q)
        2'b00: mem[addr_q] <= di_q[7:0];
        2'b01: begin
          mem[addr_q] <= di_q[15:8];
          mem[a1]     <= di_q[7:0];
        end
        default: begin
          mem[addr_q] <= di_q[31:24];
          mem[a1]     <= di_q[23:16];
          mem[a2]     <= di_q[15:8];
          mem[a3]     <= di_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance against a byte-array model, plus a WAIT_CYCLES=0 instance for BUSY/READY timing.
module tb_dmem_responder;

  localparam int WAITC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, rw, ready, err, busy;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] di, dout;

  logic        req0, rw0, ready0, err0, busy0;
  logic [1:0]  size0;
  logic [7:0]  addr0;
  logic [31:0] di0, dout0;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [256];

  dmem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(WAITC)) dut (
    .CLK(clk), .RST(rst_n), .REQ(req), .RW(rw), .SIZE(size), .ADDR(addr), .DI(di),
    .DO(dout), .READY(ready), .ERR(err), .BUSY(busy)
  );

  dmem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RST(rst_n), .REQ(req0), .RW(rw0), .SIZE(size0), .ADDR(addr0), .DI(di0),
    .DO(dout0), .READY(ready0), .ERR(err0), .BUSY(busy0)
  );

  // Reference: a byte array, big-endian, with the alignment rules applied directly.
  task automatic model_access(input logic rw_i, input logic [1:0] size_i, input logic [7:0] addr_i,
                              input logic [31:0] di_i, output logic [31:0] exp_do, output logic exp_err);
    int n;
    n = 1 << size_i;
    exp_err = (size_i == 2'b11) || ((int'(addr_i) % n) != 0);
    exp_do = 32'h0;
    if (!exp_err) begin
      if (rw_i) begin
        for (int i = 0; i < n; i++) model_mem[(int'(addr_i) + i) % 256] = 8'(di_i >> (8 * (n - 1 - i)));
      end else begin
        for (int i = 0; i < n; i++) exp_do = (exp_do << 8) | 32'(model_mem[(int'(addr_i) + i) % 256]);
`ifdef DMEM_SIGN_EXTEND_EN
        if (n < 4 && exp_do[8*n-1]) exp_do = exp_do | ~((32'h1 << (8 * n)) - 32'h1);
`endif
      end
    end
  endtask

  task automatic txn(input logic rw_i, input logic [1:0] size_i, input logic [7:0] addr_i,
                     input logic [31:0] di_i, output logic [31:0] do_o, output logic err_o, output int lat_o);
    bit seen;
    @(negedge clk);
    req = 1'b1; rw = rw_i; size = size_i; addr = addr_i; di = di_i;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_capture got=%b want=1", busy); end
    @(posedge clk);
    #1 req = 1'b0;
    do_o = 'x; err_o = 1'bx; lat_o = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      lat_o = i;
      checks++;
      if (ready === 1'b1) begin
        seen = 1; do_o = dout; err_o = err;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_resp got=%b want=0", busy); end
      end else if (busy !== 1'b1) begin
        failures++; $display("[TB] FAIL busy_wait got=%b want=1", busy);
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("[TB] FAIL ready_timeout got=no READY want=READY within 20 cycles");
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || dout !== do_o || err !== err_o) begin
      failures++;
      $display("[TB] FAIL hold got=ready %b do %h err %b want=ready 0 do %h err %b", ready, dout, err, do_o, err_o);
    end
  endtask

  task automatic txn_check(input logic rw_i, input logic [1:0] size_i, input logic [7:0] addr_i,
                           input logic [31:0] di_i, input string name, output logic [31:0] got_do);
    logic [31:0] exp_do;
    logic exp_err, got_err;
    int lat;
    model_access(rw_i, size_i, addr_i, di_i, exp_do, exp_err);
    txn(rw_i, size_i, addr_i, di_i, got_do, got_err, lat);
    checks++;
    if (lat != WAITC + 1) begin failures++; $display("[TB] FAIL %s_latency got=%0d want=%0d", name, lat, WAITC + 1); end
    checks++;
    if (got_err !== exp_err) begin failures++; $display("[TB] FAIL %s_err got=%b want=%b", name, got_err, exp_err); end
    checks++;
    if (got_do !== exp_do) begin failures++; $display("[TB] FAIL %s_do got=%h want=%h", name, got_do, exp_do); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dout !== 32'h0 || ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_outputs got=do %h ready %b err %b busy %b want=all 0", dout, ready, err, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dout !== 32'h0 || ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_outputs got=do %h ready %b err %b busy %b want=all 0", dout, ready, err, busy);
    end
  endtask

  task automatic init_memory();
    logic [31:0] d;
    for (int a = 0; a < 256; a += 4) txn_check(1'b1, 2'b10, 8'(a), 32'h0, "init", d);
  endtask

  task automatic test_word_rw();
    logic [31:0] d;
    txn_check(1'b1, 2'b10, 8'h20, 32'h12345678, "word_wr", d);
    txn_check(1'b0, 2'b10, 8'h20, 32'h0, "word_rd", d);
    checks++;
    if (d !== 32'h12345678) begin failures++; $display("[TB] FAIL word_rd_const got=%h want=12345678", d); end
    txn_check(1'b0, 2'b00, 8'h20, 32'h0, "byte_rd", d);
    checks++;
    if (d !== 32'h00000012) begin failures++; $display("[TB] FAIL byte_rd_const got=%h want=00000012", d); end
  endtask

  task automatic test_sub_word();
    logic [31:0] d;
    txn_check(1'b1, 2'b00, 8'h41, 32'hFFFFFFAB, "byte_wr", d);
    txn_check(1'b1, 2'b01, 8'h42, 32'h1234CAFE, "half_wr", d);
    txn_check(1'b0, 2'b10, 8'h40, 32'h0, "sub_rd", d);
    checks++;
    if (d !== 32'h00ABCAFE) begin failures++; $display("[TB] FAIL sub_rd_const got=%h want=00abcafe", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    txn_check(1'b1, 2'b10, 8'h30, 32'hA1B2C3D4, "err_prep", d);
    txn_check(1'b0, 2'b10, 8'h22, 32'h0, "mis_word_rd", d);
    txn_check(1'b1, 2'b01, 8'h31, 32'h00005555, "mis_half_wr", d);
    txn_check(1'b1, 2'b11, 8'h60, 32'hFFFFFFFF, "rsv_wr", d);
    txn_check(1'b0, 2'b11, 8'h30, 32'h0, "rsv_rd", d);
    txn_check(1'b0, 2'b10, 8'h30, 32'h0, "mis_target", d);
    checks++;
    if (d !== 32'hA1B2C3D4) begin failures++; $display("[TB] FAIL mis_target_const got=%h want=a1b2c3d4", d); end
    txn_check(1'b0, 2'b00, 8'h60, 32'h0, "rsv_target", d);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    txn_check(1'b1, 2'b10, 8'h10, 32'h11223344, "pre_wr", d);
    txn_check(1'b0, 2'b10, 8'h10, 32'h0, "pre_rd", d);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; size = 2'b10; addr = 8'h10; di = 32'hDEADBEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0 || ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset got=do %h ready %b err %b busy %b want=all 0", dout, ready, err, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn_check(1'b0, 2'b10, 8'h10, 32'h0, "post_rst_rd", d);
    checks++;
    if (d !== 32'h11223344) begin failures++; $display("[TB] FAIL post_rst_const got=%h want=11223344", d); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] d, want;
`ifdef DMEM_SIGN_EXTEND_EN
    want = 32'hFFFFFF80;
`else
    want = 32'h00000080;
`endif
    txn_check(1'b1, 2'b00, 8'h50, 32'h00000080, "sx_wr", d);
    txn_check(1'b0, 2'b00, 8'h50, 32'h0, "sx_rd", d);
    checks++;
    if (d !== want) begin failures++; $display("[TB] FAIL sx_const got=%h want=%h", d, want); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [1:0] s;
    logic [7:0] a;
    for (int i = 0; i < 80; i++) begin
      s = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1 && s != 2'b11) a = a & ~8'((1 << s) - 1);
      txn_check(1'($urandom), s, a, $urandom, "rand", d);
    end
  endtask

  task automatic test_wait0();
    @(negedge clk);
    req0 = 1'b1; rw0 = 1'b1; size0 = 2'b00; addr0 = 8'h07; di0 = 32'h0000005A;
    #1;
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("[TB] FAIL w0_busy_cap got=%b want=1", busy0); end
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b0 || dout0 !== 32'h0) begin
      failures++; $display("[TB] FAIL w0_wr_resp got=ready %b busy %b err %b do %h want=1 0 0 0", ready0, busy0, err0, dout0);
    end
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("[TB] FAIL w0_idle got=ready %b busy %b want=0 0", ready0, busy0);
    end
    rw0 = 1'b0; req0 = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (ready0 !== 1'(i % 2) || busy0 !== 1'(1 - i % 2)) begin
        failures++; $display("[TB] FAIL w0_b2b_%0d got=ready %b busy %b want=ready %0d busy %0d", i, ready0, busy0, i % 2, 1 - i % 2);
      end
      if (i % 2 == 1) begin
        checks++;
        if (dout0 !== 32'h0000005A) begin failures++; $display("[TB] FAIL w0_rd_%0d got=%h want=0000005a", i, dout0); end
      end
    end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; rw = 1'b0; size = 2'b00; addr = 8'h0; di = 32'h0;
    req0 = 1'b0; rw0 = 1'b0; size0 = 2'b00; addr0 = 8'h0; di0 = 32'h0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h0;
    test_reset();
    init_memory();
    test_word_rw();
    test_sub_word();
    test_errors();
    test_reset_mid();
    test_sign_ext();
    test_wait0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog got=still running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that answers the load/store requests issued by the MEM pipeline stage. The request side (enable, read/write, size, address, store data) matches the RAM control bundle the MEM stage already drives. The block adds wait states, a stall output and a ready/error response, so the pipeline can move from a zero-latency combinational RAM to a realistic memory. Storage is big-endian and byte-addressed, consistent with PA-RISC.

Parameters:
DEPTH, 256, number of bytes of storage.
ADDR_W, 8, address width in bits (log2 DEPTH).
WAIT_CYCLES, 2, wait states inserted between accepting a request and responding (0..15).

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  asynchronous reset, active-low.
REQ  in  1  request valid (RAM_CTRL[0] from the MEM stage).
RW  in  1  0 = read, 1 = write (RAM_CTRL[1]).
SIZE  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (RAM_CTRL[3:2]).
ADDR  in  ADDR_W  byte address.
DI  in  32  store data, right-justified.
DO  out  32  load data, right-justified.
READY  out  1  one-cycle response strobe.
ERR  out  1  error flag, valid only while READY=1.
BUSY  out  1  stall request to the hazard unit.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE; DO=0, READY=0, ERR=0, BUSY=0, wait counter=0.
  - Memory array is not cleared.
  - A request in flight is discarded; a pending write is never committed.
- Request capture:
  - REQ, RW, SIZE, ADDR and DI are captured only in IDLE with REQ=1, on the rising edge.
  - Inputs are ignored in every other state.
- State machine (IDLE, WAIT, RESP):
  - IDLE, REQ=1: go to WAIT with counter=WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RESP.
  - WAIT: counter decrements each cycle; at 0, go to RESP.
  - RESP: READY=1 for exactly one cycle; next state is IDLE unconditionally.
- BUSY:
  - BUSY=1 in WAIT, and in IDLE during the cycle REQ is sampled high (combinational from REQ in IDLE).
  - BUSY=0 in RESP.
  - The pipeline is held until READY.
- Latency: READY asserts WAIT_CYCLES+1 cycles after the capture edge (default 3).
- Alignment check, evaluated on the captured request:
  - Halfword requires ADDR[0]=0.
  - Word requires ADDR[1:0]=00.
  - SIZE=11 is always an error.
  - On violation: ERR=1 with READY, DO=0, and no write.
- Reads:
  - Data is sampled from the array in RESP.
  - Byte: DO = {24'b0, M[A]}.
  - Halfword: DO = {16'b0, M[A], M[A+1]}.
  - Word: DO = {M[A], M[A+1], M[A+2], M[A+3]}; M[A] is the MSB.
- Writes:
  - Committed on the edge that leaves RESP.
  - Byte writes DI[7:0]; halfword writes DI[15:0]; word writes DI[31:0], big-endian.
  - DO=0 for writes.
- DO and ERR hold their values after READY drops, until the next RESP or reset.
- Address wrap cannot occur because aligned accesses stay inside DEPTH; DEPTH must be a multiple of 4.
- REQ held high after READY starts a new transaction from IDLE; this gives back-to-back requests with one idle cycle between them.

Optional Feature:
Macro DMEM_SIGN_EXTEND_EN.
- Defined: byte and halfword reads are sign-extended from bit 7 or bit 15 respectively.
- Undefined: byte and halfword reads are zero-extended.
- Word reads, writes and error handling are identical in both builds.

Test Plan:
- Reset mid-request: assert REQ=1, RW=1, SIZE=10, ADDR=0x10, DI=0xDEADBEEF; pull RST low during WAIT -> outputs are 0 immediately, and a later word read of 0x10 returns the pre-reset contents.
- Word write then read with WAIT_CYCLES=2: write 0x12345678 to 0x20, then read word 0x20 -> READY 3 cycles after capture, DO=0x12345678, byte read of 0x20 returns 0x00000012.
- Halfword and byte writes: write byte 0xAB to 0x41 over zeroed memory, then halfword 0xCAFE to 0x42; read word 0x40 -> DO=0x00ABCAFE.
- Misalignment and reserved size: word read at 0x22, halfword write at 0x31, and any access with SIZE=11 -> each gives READY=1, ERR=1, DO=0, and the target bytes are unchanged.
- WAIT_CYCLES=0 and BUSY timing: a read asserts BUSY only in the capture cycle, and READY follows on the next cycle; REQ held high produces READY every 2 cycles.
- DMEM_SIGN_EXTEND_EN: M[0x50]=0x80, byte read of 0x50 -> DO=0xFFFFFF80 when defined, 0x00000080 when undefined.
